// File: rtl/aes_sbox_pkg.sv
// Shared types, sizes and GF(2^8) helpers for the time-multiplexed S-box bank.
package aes_sbox_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ST_RUN,
        ST_DONE,
        KEY_RUN,
        KEY_DONE
    } arb_state_t;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned NUM_WORDS = 4;
    localparam int unsigned CNT_W     = $clog2(NUM_WORDS);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = '0;
        aa = a;
        bb = b;
        for (int unsigned i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            bb = bb >> 1;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as x^254 (maps 0 to 0), followed by the AES affine transform.
    function automatic logic [7:0] sbox_byte(input logic [7:0] x);
        logic [7:0] t;
        logic [7:0] inv;
        t   = x;
        inv = 8'h01;
        for (int unsigned i = 0; i < 7; i++) begin
            t   = gf_mul(t, t);
            inv = gf_mul(inv, t);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/sbox_share_arbiter_sub_word.sv
// Combinational SubWord: four byte S-boxes forming the shared 32-bit bank.
module s_box
    import aes_sbox_pkg::*;
(
    input  logic [7:0] x,
    output logic [7:0] s
);
    assign s = sbox_byte(x);
endmodule

module sub_word
    import aes_sbox_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    output logic [WORD_W-1:0] sub
);
    for (genvar g = 0; g < 4; g++) begin : g_byte
        s_box u_s_box (
            .x (word[g*8 +: 8]),
            .s (sub[g*8 +: 8])
        );
    end
endmodule

// File: rtl/sbox_share_arbiter.sv
// Arbitrates one SubWord bank between a word-serial 128-bit SubBytes job and a SubWord job.
module sbox_share_arbiter
    import aes_sbox_pkg::*;
#(
    parameter int unsigned KEY_PRIORITY = 1,
    parameter int unsigned NUM_WORDS    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          st_req_valid,
    output logic                          st_req_ready,
    input  logic [NUM_WORDS*WORD_W-1:0]   st_in,
    output logic                          st_rsp_valid,
    input  logic                          st_rsp_ready,
    output logic [NUM_WORDS*WORD_W-1:0]   st_out,
    input  logic                          key_req_valid,
    output logic                          key_req_ready,
    input  logic [WORD_W-1:0]             key_in,
    output logic                          key_rsp_valid,
    input  logic                          key_rsp_ready,
    output logic [WORD_W-1:0]             key_out,
    output logic                          busy
);
    localparam int unsigned ST_W = NUM_WORDS * WORD_W;

    arb_state_t          state;
    logic [CNT_W-1:0]    cnt;
    logic [ST_W-1:0]     st_buf;
    logic [WORD_W-1:0]   key_buf;
    logic                rr_key;
    logic                grant_st;
    logic                grant_key;
    logic [WORD_W-1:0]   bank_in;
    logic [WORD_W-1:0]   bank_out;

    always_comb begin
        grant_key = key_req_valid && (!st_req_valid || (KEY_PRIORITY != 0) || rr_key);
        grant_st  = st_req_valid && !grant_key;
    end

    assign st_req_ready  = rst_n && (state == IDLE) && grant_st;
    assign key_req_ready = rst_n && (state == IDLE) && grant_key;
    assign busy          = (state != IDLE);

    // st_buf shifts left each run cycle, so the word under substitution is always on top.
    always_comb begin
        case (state)
            ST_RUN:  bank_in = st_buf[ST_W-1 -: WORD_W];
            KEY_RUN: bank_in = key_buf;
            default: bank_in = '0;
        endcase
    end

    sub_word u_bank (
        .word (bank_in),
        .sub  (bank_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            st_buf        <= '0;
            key_buf       <= '0;
            rr_key        <= 1'b0;
            st_out        <= '0;
            key_out       <= '0;
            st_rsp_valid  <= 1'b0;
            key_rsp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_req_valid && key_req_ready) begin
                        key_buf <= key_in;
                        rr_key  <= 1'b0;
                        state   <= KEY_RUN;
                    end else if (st_req_valid && st_req_ready) begin
                        st_buf  <= st_in;
                        cnt     <= '0;
                        rr_key  <= 1'b1;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                        if (cnt == CNT_W'(i))
                            st_out[(NUM_WORDS-1-i)*WORD_W +: WORD_W] <= bank_out;
                    end
                    st_buf <= {st_buf[ST_W-WORD_W-1:0], {WORD_W{1'b0}}};
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(NUM_WORDS-1)) begin
                        st_rsp_valid <= 1'b1;
                        state        <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (st_rsp_ready) begin
                        st_rsp_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                KEY_RUN: begin
                    key_out       <= bank_out;
                    key_rsp_valid <= 1'b1;
                    state         <= KEY_DONE;
                end
                KEY_DONE: begin
                    if (key_rsp_ready) begin
                        key_rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
